// File: rtl/hb_decim_mc.sv
// hb_decim_mc: multi-channel halfband decimate-by-2 filter with one shared
// pre-add MAC. Channels are interleaved on a single valid/ready input. Every
// second accepted sample of a channel triggers an NU-cycle MAC pass and then
// a one-cycle centre-tap/round stage.
// Optional feature: define HB_DECIM_SAT_EN to clamp out-of-range results;
// otherwise the low DW bits are kept and overflow wraps.
module hb_decim_mc #(
  parameter  int DW   = 18,
  parameter  int CW   = 25,
  parameter  int FRAC = 16,
  parameter  int TAPS = 7,
  parameter  int NCH  = 2,
  localparam int NU   = (TAPS + 1) / 4,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int NUW  = (NU > 1) ? $clog2(NU) : 1
) (
  input  logic                 MACCLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [DW-1:0] in_data,
  input  logic                 coef_we,
  input  logic [NUW-1:0]       coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [DW-1:0] out_data
);

  localparam int AW = DW + CW + $clog2(NU) + 2;
  localparam int PW = DW + CW + 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0] hist [NCH][TAPS];
  logic [NCH-1:0]       phase;
  logic signed [CW-1:0] coef [NU];
  logic [CHW-1:0]       ch_q;
  logic [NUW-1:0]       j;
  logic signed [AW-1:0] acc;

  logic                 accept;
  logic                 ch_ok;
  logic                 phase_sel;
  logic                 start;
  logic                 coef_wr;

  logic signed [DW-1:0] hsel [TAPS];
  logic signed [DW-1:0] tap_a;
  logic signed [DW-1:0] tap_b;
  logic signed [CW-1:0] csel;
  logic signed [DW:0]   pre;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;
  logic signed [DW-1:0] res_dw;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign ch_ok    = (32'(in_ch) < NCH);
  assign start    = accept & ch_ok & ~phase_sel;
  assign coef_wr  = coef_we & (state_q == IDLE) & ~accept & (32'(coef_addr) < NU);

  // Current phase bit of the offered channel (0 means this sample starts a computation)
  always_comb begin
    phase_sel = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (c == 32'(in_ch)) phase_sel = phase[c];
    end
  end

  // FSM state register
  always_ff @(posedge MACCLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: IDLE waits for a phase 0->1 accept, MAC runs NU steps, OUT is one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = MAC;
      MAC:  if (32'(j) == NU - 1) state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-channel history shift and phase toggle on every accepted in-range sample
  always_ff @(posedge MACCLK or posedge RST) begin
    if (RST) begin
      phase <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end
    end else if (accept && ch_ok) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (c == 32'(in_ch)) begin
          hist[c][0] <= in_data;
          for (int unsigned t = 1; t < TAPS; t++) hist[c][t] <= hist[c][t-1];
          phase[c] <= ~phase[c];
        end
      end
    end
  end

  // Coefficient RAM, writable only while idle and not on an accepting edge
  always_ff @(posedge MACCLK or posedge RST) begin
    if (RST) begin
      for (int unsigned u = 0; u < NU; u++) coef[u] <= '0;
    end else if (coef_wr) begin
      for (int unsigned u = 0; u < NU; u++) begin
        if (u == 32'(coef_addr)) coef[u] <= coef_data;
      end
    end
  end

  // Operand select for the latched channel and the current symmetric tap pair
  always_comb begin
    hsel = hist[0];
    for (int unsigned c = 0; c < NCH; c++) begin
      if (c == 32'(ch_q)) hsel = hist[c];
    end
    tap_a = '0;
    tap_b = '0;
    csel  = '0;
    for (int unsigned u = 0; u < NU; u++) begin
      if (u == 32'(j)) begin
        tap_a = hsel[2*u];
        tap_b = hsel[TAPS-1-2*u];
        csel  = coef[u];
      end
    end
  end

  // Pre-add, multiply and final centre-tap sum with result scaling
  always_comb begin
    pre  = {tap_a[DW-1], tap_a} + {tap_b[DW-1], tap_b};
    prod = PW'(pre) * PW'(csel);
    sum  = acc + (AW'(hsel[(TAPS-1)/2]) <<< (FRAC - 1));
`ifdef HB_DECIM_SAT_EN
    begin
      logic signed [AW-1:0] shr;
      logic                 ovf;
      shr = sum >>> FRAC;
      ovf = ~((&shr[AW-1:DW-1]) | ~(|shr[AW-1:DW-1]));
      if (ovf) res_dw = shr[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else     res_dw = shr[DW-1:0];
    end
`else
    res_dw = DW'(sum >>> FRAC);
`endif
  end

  // MAC accumulator, tap index, channel latch and registered output
  always_ff @(posedge MACCLK or posedge RST) begin
    if (RST) begin
      ch_q      <= '0;
      j         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (start) begin
        ch_q <= in_ch;
        j    <= '0;
        acc  <= '0;
      end
      if (state_q == MAC) begin
        acc <= acc + AW'(prod);
        j   <= j + NUW'(1);
      end
      if (state_q == OUT) begin
        out_valid <= 1'b1;
        out_ch    <= ch_q;
        out_data  <= res_dw;
      end
    end
  end

endmodule
